// File: rtl/riskproc_pkg.sv
// Shared types and constants for the register-file read path.
// Sizes, the output-buffer state encoding and the operand-pair record.
package riskproc_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NREGS     = 32;
    localparam int unsigned REG_IDX_W = $clog2(NREGS);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
    } opnd_pair_t;

    // Register 0 is hardwired to zero and wins over any write-bus bypass.
    function automatic logic [XLEN-1:0] operand_sel(
        input logic [REG_IDX_W-1:0] idx,
        input logic [XLEN-1:0]      reg_val,
        input logic                 bypass,
        input logic [XLEN-1:0]      wdata
    );
        if (idx == '0) begin
            return '0;
        end else if (bypass) begin
            return wdata;
        end else begin
            return reg_val;
        end
    endfunction

endpackage

// File: rtl/regread_if.sv
// Request/response handshake bundle between decode and the register read block.
interface regread_if;
    import riskproc_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;

    modport slave (
        input  req_valid, rs1, rs2, rsp_ready,
        output req_ready, rsp_valid, rs1_data, rs2_data
    );

    modport master (
        output req_valid, rs1, rs2, rsp_ready,
        input  req_ready, rsp_valid, rs1_data, rs2_data
    );

endinterface

// File: rtl/rf_skid_buf.sv
// Two-entry valid/ready buffer of operand pairs; outputs always show the head entry.
// ready_o depends on registered state only, never on pop_ready_i.
module rf_skid_buf
    import riskproc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  opnd_pair_t data_i,
    output logic       ready_o,
    output logic       valid_o,
    input  logic       pop_ready_i,
    output opnd_pair_t data_o
);

    buf_state_e state_q, state_d;
    opnd_pair_t head_q, head_d;
    opnd_pair_t tail_q, tail_d;
    logic       accept;
    logic       pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        ready_o = (state_q != TWO);
        valid_o = (state_q != EMPTY);
        data_o  = head_q;
        accept  = push_i && ready_o;
        pop     = valid_o && pop_ready_i;

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_d  = data_i;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    tail_d  = data_i;
                    state_d = TWO;
                end else if (accept && pop) begin
                    head_d  = data_i;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

endmodule

// File: rtl/regread.sv
// Two-port register read: snapshots rs1/rs2 operands (with write-bus bypass)
// at request acceptance and delivers them through a two-entry response buffer.
module regread
    import riskproc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREGS*XLEN-1:0] regs,
    input  logic [XLEN-1:0]       G,
    input  logic [NREGS-1:0]      R_in,
    regread_if.slave              rr
);

    logic [XLEN-1:0] regs_a [NREGS];
    opnd_pair_t      snap;
    opnd_pair_t      head;
    logic            buf_ready;
    logic            buf_valid;

    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            regs_a[i] = regs[XLEN*i +: XLEN];
        end
    end

    always_comb begin
        snap          = '0;
        snap.rs1_data = operand_sel(rr.rs1, regs_a[rr.rs1], R_in[rr.rs1], G);
        snap.rs2_data = operand_sel(rr.rs2, regs_a[rr.rs2], R_in[rr.rs2], G);
    end

    rf_skid_buf u_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (rr.req_valid),
        .data_i      (snap),
        .ready_o     (buf_ready),
        .valid_o     (buf_valid),
        .pop_ready_i (rr.rsp_ready),
        .data_o      (head)
    );

    assign rr.req_ready = buf_ready;
    assign rr.rsp_valid = buf_valid;
    assign rr.rs1_data  = head.rs1_data;
    assign rr.rs2_data  = head.rs2_data;

endmodule
